hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised pipeline hazard controller for the five-stage MIPS pipeline; the successor to the single-cycle load-use stall unit. It does four things:
- Detects load-use hazards between the ID/EX instruction and the IF/ID instruction, using an exact per-format source-register check.
- Stalls for a configurable load latency using a counter-driven state machine.
- Freezes the whole pipeline while data memory is busy.
- Flushes IF/ID and ID/EX on a taken branch.

It sits between the pipeline registers and the PC logic, and it drives every write-enable and flush in the core.

## Interface
Parameters:
- LOAD_STALL, 1, bubble cycles inserted per load-use hazard (1..7).
- CNT_W, 3, stall counter width; must satisfy 2^CNT_W > LOAD_STALL.
- PERF_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instruction_ir  in  32  IF/ID register instruction (consumer in ID).
- instruction_lw  in  32  ID/EX register instruction (candidate load in EX).
- mem_busy  in  1  data memory not ready this cycle.
- branch_taken  in  1  branch resolved taken in EX this cycle.
- pc_write  out  1  1 = PC loads next value; 0 = PC holds.
- if_id_write  out  1  1 = IF/ID captures; 0 = holds.
- if_id_flush  out  1  1 = IF/ID cleared to nop at next edge.
- id_exe_write  out  1  1 = ID/EX captures.
- id_exe_flush  out  1  1 = ID/EX cleared to nop at next edge.
- exe_mem_write  out  1  1 = EX/MEM captures.
- stalling  out  1  1 while in LU_STALL state.
- stall_count  out  PERF_W  saturating count of cycles with pc_write=0.

## Operation
Load detect:
- A load is present when instruction_lw[31:26]=6'b100011.
- Its destination is lt = instruction_lw[20:16].
- lt=0 never hazards.

Consumer sources, selected by the opcode of instruction_ir:
- 000000 (R-type): rs[25:21] and rt[20:16].
- 101011 (sw), 000100 (beq), 000101 (bne): rs and rt.
- 000010 (j), 000011 (jal): none.
- All other opcodes, including lw and I-type ALU ops: rs only.

hazard = load & lt≠0 & lt matches any source of the consumer.

States:
- IDLE.
- LU_STALL: holds cnt[CNT_W-1:0].

Output priority, highest first:
1. mem_busy=1 (any state): pc_write=0, if_id_write=0, id_exe_write=0, exe_mem_write=0; both flushes 0. State and cnt are frozen.
2. branch_taken=1: pc_write=1, all writes 1, if_id_flush=1, id_exe_flush=1. Next state is IDLE and cnt is cleared, aborting any stall.
3. In LU_STALL: pc_write=0, if_id_write=0, id_exe_flush=1, other writes 1. hazard is ignored.
   - cnt>1: cnt decrements.
   - cnt=1: next state IDLE.
4. In IDLE with hazard=1: pc_write=0, if_id_write=0, id_exe_flush=1, other writes 1.
   - LOAD_STALL>1: next state LU_STALL with cnt=LOAD_STALL-1.
   - LOAD_STALL=1: stay in IDLE.
5. Otherwise: all writes 1, both flushes 0.

Other rules:
- stall_count increments on every cycle with pc_write=0 and saturates at all-ones.
- stalling=1 exactly when state=LU_STALL.

## Timing
- Detection is combinational: a hazard present in cycle T produces a stall in cycle T with no latency.
- A load-use hazard produces exactly LOAD_STALL consecutive cycles of pc_write=0 when mem_busy=0 throughout.
- mem_busy cycles extend that window 1:1 and never consume stall budget.
- State, cnt and stall_count update on the rising clk edge.
- Reset, while rst=1 at an edge:
  - state→IDLE, cnt→0, stall_count→0.
  - During those rst cycles, outputs are forced to pc_write=1, if_id_write=1, id_exe_write=1, exe_mem_write=1, if_id_flush=0, id_exe_flush=0, stalling=0, regardless of other inputs.
- Reset asserted mid-stall aborts the stall. The first cycle after rst deasserts evaluates as IDLE.
- mem_busy and branch_taken together: mem_busy wins and branch_taken is ignored that cycle. EX holds, so the branch is re-presented on the next cycle.
- The stall_count increment is blocked only by saturation, never by mem_busy.

## Test plan
- LOAD_STALL=1. Set lw $5 in EX and add $3,$5,$2 in ID → one cycle of pc_write=0, if_id_write=0, id_exe_flush=1; then no stall the next cycle; stall_count=1.
- LOAD_STALL=3. Set lw $7 in EX and sw $7,0($4) in ID → pc_write=0 for exactly 3 cycles; stalling=1 for cycles 2–3; stall_count=3. Then repeat with lw $7 in EX and lw $9,0($7) in ID, a hazard on rs → identical 3-cycle stall.
- lw $0 in EX and add $1,$0,$0 in ID → no stall. Then lw $6 in EX and addi $6,$8,1 in ID, where rt is only written by the consumer → no stall.
- LOAD_STALL=3 with hazard. Raise mem_busy for 2 cycles during the second stall cycle → all writes 0 for those 2 cycles; the stall then resumes; total pc_write=0 cycles = 5; stall_count=5.
- branch_taken=1 alone → if_id_flush=1, id_exe_flush=1, pc_write=1. Then raise branch_taken and mem_busy together → all writes 0 and both flushes 0.
- LOAD_STALL=3. Assert rst during the second stall cycle → outputs take their reset values; stall_count=0; the next cycle with no hazard has pc_write=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage MIPS pipeline: load-use stall sequencing,
// memory-busy freeze, taken-branch flush, and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 3,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction_ir,
  input  logic [31:0]       instruction_lw,
  input  logic              mem_busy,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_exe_write,
  output logic              id_exe_flush,
  output logic              exe_mem_write,
  output logic              stalling,
  output logic [PERF_W-1:0] stall_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam bit             MULTI_STALL = (LOAD_STALL > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {IDLE, LU_STALL} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             is_load, use_rs, use_rt, hazard;
  logic [4:0]       lt, rs, rt;
  logic [5:0]       op;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  // Fields of the load and the consumer that the hazard check never looks at.
  logic unused_bits;
  assign unused_bits = ^{instruction_lw[25:21], instruction_lw[15:0], instruction_ir[15:0]};

  assign is_load = (instruction_lw[31:26] == OP_LW);
  assign lt      = instruction_lw[20:16];
  assign op      = instruction_ir[31:26];
  assign rs      = instruction_ir[25:21];
  assign rt      = instruction_ir[20:16];

  // Which source fields the consumer actually reads; rt of an I-type is a destination.
  always_comb begin
    use_rs = 1'b1;
    use_rt = 1'b0;
    case (op)
      OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: use_rt = 1'b1;
      OP_J, OP_JAL:                    use_rs = 1'b0;
      default:                         ;
    endcase
  end

  assign hazard = is_load && (lt != 5'd0) &&
                  ((use_rs && (rs == lt)) || (use_rt && (rt == lt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (mem_busy) begin
      state_next = state;
      cnt_next   = cnt;
    end else if (branch_taken) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (state == LU_STALL) begin
      if (cnt > CNT_ONE) begin
        cnt_next = cnt - CNT_ONE;
      end else begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    end else if (hazard && MULTI_STALL) begin
      state_next = LU_STALL;
      cnt_next   = CNT_LOAD;
    end
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_exe_write  = 1'b1;
    exe_mem_write = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    if (rst) begin
      pc_write = 1'b1;
    end else if (mem_busy) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_exe_write  = 1'b0;
      exe_mem_write = 1'b0;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
    end else if ((state == LU_STALL) || hazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_exe_flush = 1'b1;
    end
  end

  assign stalling = (state == LU_STALL) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!pc_write) begin
      stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (3-cycle and 1-cycle load stall) on shared
// inputs, driven from a cycle table with queued expectations.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction_ir = '0;
  logic [31:0] instruction_lw = '0;
  logic        mem_busy = 1'b0;
  logic        branch_taken = 1'b0;

  logic        pc3, ifw3, iff3, idw3, idf3, emw3, stl3;
  logic [15:0] sc3;
  logic        pc1, ifw1, iff1, idw1, idf1, emw1, stl1;
  logic [2:0]  sc1;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL(3), .CNT_W(3), .PERF_W(16)) dut3 (
    .clk(clk), .rst(rst), .instruction_ir(instruction_ir), .instruction_lw(instruction_lw),
    .mem_busy(mem_busy), .branch_taken(branch_taken),
    .pc_write(pc3), .if_id_write(ifw3), .if_id_flush(iff3), .id_exe_write(idw3),
    .id_exe_flush(idf3), .exe_mem_write(emw3), .stalling(stl3), .stall_count(sc3)
  );

  hazard_ctrl #(.LOAD_STALL(1), .CNT_W(2), .PERF_W(3)) dut1 (
    .clk(clk), .rst(rst), .instruction_ir(instruction_ir), .instruction_lw(instruction_lw),
    .mem_busy(mem_busy), .branch_taken(branch_taken),
    .pc_write(pc1), .if_id_write(ifw1), .if_id_flush(iff1), .id_exe_write(idw1),
    .id_exe_flush(idf1), .exe_mem_write(emw1), .stalling(stl1), .stall_count(sc1)
  );

  typedef struct {
    int          id;
    logic        rst;
    logic        busy;
    logic        br;
    logic [31:0] lw;
    logic [31:0] ir;
    bit          sel1;
    logic [6:0]  ctl;
    int unsigned sc;
  } vec_t;

  // ctl = {pc_write, if_id_write, if_id_flush, id_exe_write, id_exe_flush, exe_mem_write, stalling}
  localparam logic [6:0] C_NORM   = 7'b1101010;
  localparam logic [6:0] C_HAZ    = 7'b0001110;
  localparam logic [6:0] C_LU     = 7'b0001111;
  localparam logic [6:0] C_BUSY   = 7'b0000000;
  localparam logic [6:0] C_BUSYLU = 7'b0000001;
  localparam logic [6:0] C_BR     = 7'b1111110;
  localparam logic [6:0] C_BRLU   = 7'b1111111;

  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];
  vec_t sb[$];

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'h0004};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic vec_t mk(input logic r, input logic b, input logic br,
                              input logic [31:0] lw, input logic [31:0] ir,
                              input bit s1, input logic [6:0] ctl, input int unsigned sc);
    vec_t v;
    v.id = 0; v.rst = r; v.busy = b; v.br = br; v.lw = lw; v.ir = ir;
    v.sel1 = s1; v.ctl = ctl; v.sc = sc;
    return v;
  endfunction

  task automatic check_row(input vec_t r);
    logic [6:0]  got;
    int unsigned gsc;
    if (r.sel1) begin
      got = {pc1, ifw1, iff1, idw1, idf1, emw1, stl1};
      gsc = 32'(sc1);
    end else begin
      got = {pc3, ifw3, iff3, idw3, idf3, emw3, stl3};
      gsc = 32'(sc3);
    end
    checks++;
    if (got !== r.ctl) begin
      errors++;
      $display("FAIL row%0d ctl: got=%b want=%b", r.id, got, r.ctl);
    end
    checks++;
    if (gsc !== r.sc) begin
      errors++;
      $display("FAIL row%0d stall_count: got=%0d want=%0d", r.id, gsc, r.sc);
    end
  endtask

  task automatic run_row(input vec_t r);
    vec_t e;
    @(posedge clk);
    #1;
    rst = r.rst; mem_busy = r.busy; branch_taken = r.br;
    instruction_lw = r.lw; instruction_ir = r.ir;
    sb.push_back(r);
    @(negedge clk);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL row%0d scoreboard empty", r.id);
    end else begin
      e = sb.pop_front();
      check_row(e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] nop, lw5, add_hz, lw7, sw7, lw9, lw0, add0, lw6, addi6, jmp, beq7;
    vec_t v;
    nop    = '0;
    lw5    = itype(6'b100011, 5'd0, 5'd5);
    add_hz = rtype(5'd5, 5'd2, 5'd3);
    lw7    = itype(6'b100011, 5'd0, 5'd7);
    sw7    = itype(6'b101011, 5'd4, 5'd7);
    lw9    = itype(6'b100011, 5'd7, 5'd9);
    lw0    = itype(6'b100011, 5'd0, 5'd0);
    add0   = rtype(5'd0, 5'd0, 5'd1);
    lw6    = itype(6'b100011, 5'd0, 5'd6);
    addi6  = itype(6'b001000, 5'd8, 5'd6);
    jmp    = itype(6'b000010, 5'd7, 5'd7);
    beq7   = itype(6'b000100, 5'd1, 5'd7);

    //            rst   busy  br    lw    ir      sel1 ctl       sc
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, lw5,  add_hz, 0, C_NORM,   0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, lw5,  add_hz, 1, C_HAZ,    0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  add_hz, 1, C_NORM,   1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, nop,  nop,    1, C_NORM,   1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, lw7,  sw7,    0, C_HAZ,    0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  sw7,    0, C_LU,     1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  sw7,    0, C_LU,     2));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  nop,    0, C_NORM,   3));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, lw7,  lw9,    0, C_HAZ,    3));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  lw9,    0, C_LU,     4));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  lw9,    0, C_LU,     5));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  nop,    0, C_NORM,   6));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, lw0,  add0,   0, C_NORM,   6));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, lw6,  addi6,  0, C_NORM,   6));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, lw7,  jmp,    0, C_NORM,   6));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, lw7,  beq7,   0, C_HAZ,    6));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  beq7,   0, C_LU,     7));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  beq7,   0, C_LU,     8));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  nop,    0, C_NORM,   9));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, lw7,  sw7,    0, C_HAZ,    9));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, nop,  sw7,    0, C_BUSYLU, 10));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, nop,  sw7,    0, C_BUSYLU, 11));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  sw7,    0, C_LU,     12));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  sw7,    0, C_LU,     13));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  nop,    0, C_NORM,   14));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, nop,  nop,    0, C_BR,     14));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, nop,  nop,    0, C_BUSY,   14));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, nop,  nop,    0, C_BR,     15));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, lw7,  sw7,    0, C_HAZ,    15));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, nop,  sw7,    0, C_BRLU,   16));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  nop,    0, C_NORM,   16));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, lw7,  sw7,    0, C_BUSY,   16));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, lw7,  sw7,    0, C_HAZ,    17));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  sw7,    0, C_LU,     18));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  sw7,    0, C_LU,     19));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  nop,    0, C_NORM,   20));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, lw7,  sw7,    0, C_HAZ,    20));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, nop,  sw7,    0, C_NORM,   21));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  nop,    0, C_NORM,   0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, lw7,  sw7,    0, C_NORM,   0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, nop,  nop,    0, C_NORM,   0));

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      v.id = i;
      run_row(v);
    end

    // Continuous hazards on the single-bubble instance drive its 3-bit counter into saturation.
    @(posedge clk);
    #1;
    rst = 1'b1; mem_busy = 1'b0; branch_taken = 1'b0;
    instruction_lw = nop; instruction_ir = nop;
    for (int i = 0; i < 10; i++) begin
      v = mk(1'b0, 1'b0, 1'b0, lw5, add_hz, 1, C_HAZ, (i > 7) ? 7 : i);
      v.id = 100 + i;
      run_row(v);
    end
    v = mk(1'b0, 1'b0, 1'b0, nop, nop, 1, C_NORM, 7);
    v.id = 110;
    run_row(v);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
